// File: rtl/mem_pkg.sv
// Shared types for the data-RAM arbiter slice.
// Port indices and word width used by the arbiter and its pick logic.
package mem_pkg;
  localparam int WORD_W = 32;

  typedef logic port_t;

  localparam port_t PORT_IF  = 1'b0;
  localparam port_t PORT_LSU = 1'b1;

  function automatic port_t other(port_t p);
    return ~p;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the shared data-RAM arbiter.
// slave = arbiter side, master = requesters plus RAM model.
interface ram_arbiter_if #(
  parameter int SIZE_LOG2 = 13
);
  import mem_pkg::*;

  logic                 req0;
  logic                 we0;
  logic [SIZE_LOG2-1:0] a0;
  logic [WORD_W-1:0]    wd0;
  logic                 gnt0;
  logic                 rvalid0;
  logic [WORD_W-1:0]    rd0;

  logic                 req1;
  logic                 we1;
  logic [SIZE_LOG2-1:0] a1;
  logic [WORD_W-1:0]    wd1;
  logic                 gnt1;
  logic                 rvalid1;
  logic [WORD_W-1:0]    rd1;

  logic                 mem_we;
  logic [SIZE_LOG2-1:0] mem_a;
  logic [WORD_W-1:0]    mem_wd;
  logic [WORD_W-1:0]    mem_rd;

  modport slave (
    input  req0, we0, a0, wd0,
    input  req1, we1, a1, wd1,
    input  mem_rd,
    output gnt0, rvalid0, rd0,
    output gnt1, rvalid1, rd1,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output req0, we0, a0, wd0,
    output req1, we1, a1, wd1,
    output mem_rd,
    input  gnt0, rvalid0, rd0,
    input  gnt1, rvalid1, rd1,
    input  mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin pick with a hold limit.
// Combinational: grant vector from requests, last winner and streak count.
module rr_pick
  import mem_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic [1:0] i_req,
  input  port_t      i_last,
  input  logic [3:0] i_hold,
  output logic [1:0] o_gnt
);
  localparam logic [3:0] HMAX = 4'(MAX_HOLD);

  logic  w_keep;
  port_t w_win;

  // hold of 0 means last sat idle, so the other port gets its turn
  assign w_keep = (i_hold != 4'd0) && (i_hold < HMAX);
  assign w_win  = w_keep ? i_last : other(i_last);

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req[0] & i_req[1]): o_gnt[w_win] = 1'b1;
      default:               o_gnt = i_req;
    endcase
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port registered-read RAM between fetch and LSU.
// Round-robin with hold limit; 1-cycle read return per port.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int SIZE_LOG2 = 13,
  parameter int MAX_HOLD  = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);
  localparam logic [3:0] HMAX = 4'(MAX_HOLD);

  port_t      r_last;
  port_t      r_rd_owner;
  logic [3:0] r_hold;
  logic       r_rd_pend;

  logic [1:0]           w_pick;
  logic [1:0]           w_gnt;
  logic                 w_any;
  port_t                w_sel;
  logic                 w_we;
  logic [SIZE_LOG2-1:0] w_a;
  logic [WORD_W-1:0]    w_wd;
  logic                 w_rv0;
  logic                 w_rv1;

  rr_pick #(
    .MAX_HOLD (MAX_HOLD)
  ) u_pick (
    .i_req  ({bus.req1, bus.req0}),
    .i_last (r_last),
    .i_hold (r_hold),
    .o_gnt  (w_pick)
  );

  // grants are combinational, so mask them while reset is held
  assign w_gnt = w_pick & {2{rst}};
  assign w_any = |w_gnt;
  assign w_sel = w_gnt[1];
  assign w_we  = w_sel ? bus.we1 : bus.we0;
  assign w_a   = w_sel ? bus.a1  : bus.a0;
  assign w_wd  = w_sel ? bus.wd1 : bus.wd0;

  assign bus.gnt0   = w_gnt[0];
  assign bus.gnt1   = w_gnt[1];
  assign bus.mem_we = w_any & w_we;
  assign bus.mem_a  = w_a;
  assign bus.mem_wd = w_wd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last     <= PORT_LSU;
      r_hold     <= 4'd0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= PORT_IF;
    end else if (w_any) begin
      if (w_sel == r_last) begin
        if (r_hold != HMAX)
          r_hold <= r_hold + 4'd1;
      end else begin
        r_last <= w_sel;
        r_hold <= 4'd1;
      end
      r_rd_pend  <= ~w_we;
      r_rd_owner <= w_sel;
    end else begin
      r_hold    <= 4'd0;
      r_rd_pend <= 1'b0;
    end
  end

  assign w_rv0 = r_rd_pend & (r_rd_owner == PORT_IF);
  assign w_rv1 = r_rd_pend & (r_rd_owner == PORT_LSU);

  assign bus.rvalid0 = w_rv0;
  assign bus.rvalid1 = w_rv1;
  assign bus.rd0     = w_rv0 ? bus.mem_rd : '0;
  assign bus.rd1     = w_rv1 ? bus.mem_rd : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: grant-history model, shadow memory,
// and a response monitor fed by a queue of expected read returns.
module tb_ram_arbiter;
  import mem_pkg::*;

  localparam int AW = 13;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.SIZE_LOG2(AW)) bus ();

  ram_arbiter #(
    .SIZE_LOG2 (AW),
    .MAX_HOLD  (MH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0]    t_req = '0;
  logic [1:0]    t_we  = '0;
  logic [AW-1:0] t_a  [2];
  logic [31:0]   t_wd [2];
  logic [31:0]   ram_rd;
  logic [31:0]   ram  [0:(1<<AW)-1];
  logic [31:0]   refm [0:(1<<AW)-1];

  assign bus.req0   = t_req[0];
  assign bus.we0    = t_we[0];
  assign bus.a0     = t_a[0];
  assign bus.wd0    = t_wd[0];
  assign bus.req1   = t_req[1];
  assign bus.we1    = t_we[1];
  assign bus.a1     = t_a[1];
  assign bus.wd1    = t_wd[1];
  assign bus.mem_rd = ram_rd;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_a] <= bus.mem_wd;
    ram_rd <= ram[bus.mem_a];
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } rsp_t;
  rsp_t q[$];

  int m_last   = 1;
  int m_prev   = -1;
  int m_streak = 0;
  logic [1:0] g_seen = '0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic miss(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Winner from request pattern and recent grant history
  function automatic int predict();
    if (t_req == 2'b00) return -1;
    if (t_req == 2'b01) return 0;
    if (t_req == 2'b10) return 1;
    if (m_prev < 0)       return 1 - m_last;
    if (m_streak < MH)    return m_prev;
    return 1 - m_prev;
  endfunction

  always @(negedge rst) begin
    q.delete();
    m_last   = 1;
    m_prev   = -1;
    m_streak = 0;
  end

  always @(negedge clk) g_seen = {bus.gnt1, bus.gnt0};

  always @(negedge clk) begin : pred
    int   w;
    logic ew;
    if (rst) begin
      w  = predict();
      ew = (w >= 0) ? t_we[w] : 1'b0;
      chk("grant", {61'd0, bus.gnt1, bus.gnt0, bus.mem_we},
          {61'd0, w == 1, w == 0, ew});
      if (w >= 0) begin
        chk("mem_a", 64'(bus.mem_a), 64'(t_a[w]));
        if (t_we[w]) begin
          chk("mem_wd", 64'(bus.mem_wd), 64'(t_wd[w]));
          refm[t_a[w]] = t_wd[w];
        end else begin
          q.push_back('{cyc + 1, w, refm[t_a[w]]});
        end
        m_streak = (w == m_prev) ? m_streak + 1 : 1;
        m_prev   = w;
        m_last   = w;
      end else begin
        m_prev = -1;
      end
    end
  end

  always @(negedge clk) begin : mon
    rsp_t e;
    if (bus.rvalid0 && bus.rvalid1) begin
      miss("rvalid_both");
    end else if (bus.rvalid0 || bus.rvalid1) begin
      if (q.size() == 0) begin
        miss("unexpected_rvalid");
      end else begin
        e = q.pop_front();
        chk("rsp_port", 64'(bus.rvalid1), 64'(e.port));
        chk("rsp_time", 64'(cyc), 64'(e.due));
        chk("rsp_data", 64'(bus.rvalid1 ? bus.rd1 : bus.rd0), 64'(e.data));
        chk("rd_other", 64'(bus.rvalid1 ? bus.rd0 : bus.rd1), 64'd0);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      miss("missing_rvalid");
    end
  end

  task automatic set_req(int p, logic r, logic w, logic [AW-1:0] a,
                         logic [31:0] d);
    t_req[p] = r;
    t_we[p]  = w;
    t_a[p]   = a;
    t_wd[p]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(int p, output int n);
    logic g;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      g = p ? bus.gnt1 : bus.gnt0;
    end while (!g && n < 20);
    if (!g) miss("gnt_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic ex [10];
    ex = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]  = $urandom;
      refm[i] = ram[i];
    end
    for (int p = 0; p < 2; p++) set_req(p, 0, 0, '0, '0);

    repeat (2) tick();
    t_req = 2'b11;
    @(negedge clk);
    chk("reset_out", {59'd0, bus.gnt1, bus.gnt0, bus.rvalid1,
        bus.rvalid0, bus.mem_we}, 64'd0);
    t_req = 2'b00;
    @(posedge clk);
    #2 rst = 1'b1;

    tick();
    set_req(0, 1, 0, 13'h010, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_gnt0", 64'(bus.gnt0), 64'd1);
      chk("t1_rv0", 64'(bus.rvalid0), 64'(i > 0));
    end
    tick();
    t_req[0] = 1'b0;

    set_req(1, 1, 1, 13'h1FF, 32'hDEADBEEF);
    wait_gnt(1, n);
    set_req(1, 1, 0, 13'h1FF, '0);
    wait_gnt(1, n);
    t_req[1] = 1'b0;
    @(negedge clk);
    chk("raw_rv1", 64'(bus.rvalid1), 64'd1);
    chk("raw_rd1", 64'(bus.rd1), 64'hDEADBEEF);

    repeat (5) begin
      @(negedge clk);
      chk("idle", {59'd0, bus.gnt1, bus.gnt0, bus.mem_we,
          bus.rvalid1, bus.rvalid0}, 64'd0);
    end

    tick();
    set_req(0, 1, 0, 13'h020, '0);
    repeat (6) tick();
    set_req(1, 1, 0, 13'h030, '0);
    wait_gnt(1, n);
    chk("gap_lat", 64'(n <= MH), 64'd1);
    t_req[1] = 1'b0;
    @(negedge clk);
    chk("gap_resume", 64'(bus.gnt0), 64'd1);
    tick();
    t_req[0] = 1'b0;

    set_req(0, 1, 0, 13'h040, '0);
    wait_gnt(0, n);
    #1 rst = 1'b0;
    t_req = 2'b00;
    @(negedge clk);
    chk("rst_rv0", 64'(bus.rvalid0), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    set_req(0, 1, 0, 13'h050, '0);
    set_req(1, 1, 0, 13'h060, '0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("contend", 64'(bus.gnt1), 64'(ex[i]));
    end
    tick();
    t_req = 2'b00;
    repeat (3) tick();

    for (int i = 0; i < 2000; i++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (!t_req[p] || g_seen[p]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(p, 1, $urandom_range(0, 2) == 0,
                    AW'(32'h100 + $urandom_range(0, 7)), $urandom);
          else
            t_req[p] = 1'b0;
        end
      end
    end

    t_req = 2'b00;
    repeat (4) tick();
    chk("drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- The RAM has a registered read port: read data appears one cycle after the address is presented. Writes commit at the clock edge.
- The arbiter grants at most one access per cycle using round-robin. A hold limit lets a winner stream back-to-back without starving the other port.
- It returns read data with a per-port valid strobe and sits between the core's stage logic and the memory block.

Parameters:
- SIZE_LOG2, 13, word-address width of the shared RAM.
- MAX_HOLD, 4, maximum consecutive grants to one port while the other port is requesting (1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  port 0 access request
- we0  in  1  port 0 write enable (0 = read)
- a0  in  SIZE_LOG2  port 0 word address
- wd0  in  32  port 0 write data
- gnt0  out  1  port 0 request accepted this cycle
- rvalid0  out  1  port 0 read data valid
- rd0  out  32  port 0 read data
- req1, we1, a1, wd1, gnt1, rvalid1, rd1: same as port 0, for port 1
- mem_we  out  1  RAM write enable
- mem_a  out  SIZE_LOG2  RAM address
- mem_wd  out  32  RAM write data
- mem_rd  in  32  RAM registered read data

Behaviour:
- Handshake:
  - A requester holds req with stable we/a/wd until it sees gnt high at a rising edge. The transfer is accepted at that edge.
  - gnt is combinational from req and registered state. At most one gnt is high per cycle, and gnt is never high without its req.
- Arbitration (registered state: last, hold_cnt):
  - Only one port requesting: that port wins.
  - Both ports requesting:
    - If hold_cnt < MAX_HOLD, the port != last wins only if the port == last has not been granted; in practice, last keeps the grant.
    - Once hold_cnt reaches MAX_HOLD, the other port wins.
    - If last did not win the previous cycle (it was idle), round-robin applies: the port != last wins.
  - On a grant to port p: if p == last, hold_cnt increments (saturating at MAX_HOLD); otherwise last <= p and hold_cnt <= 1.
  - No grant in a cycle: hold_cnt <= 0, last unchanged.
- RAM drive:
  - mem_a/mem_wd come from the winning port.
  - mem_we = we of the winner and gnt.
  - With no winner, mem_we = 0 and mem_a/mem_wd = port 0 values (don't-care, kept deterministic).
- Read return:
  - A granted read sets rd_pend <= 1 and rd_owner <= p.
  - The next cycle, rvalid[rd_owner] = rd_pend, and rd[rd_owner] = mem_rd.
  - rd of the non-owner port is 0, and rvalid is 0 for both ports otherwise.
  - Read latency is exactly 1 cycle after the accepting edge. Back-to-back reads produce back-to-back rvalid.
  - A granted write clears rd_pend.
- Read-after-write:
  - Write to address X at edge N, read of X granted at edge N+1: rvalid at N+2 returns the new data.
  - The arbiter never issues a read and a write in the same cycle, so the RAM's same-cycle read/write ordering is never exercised.
- Reset (rst low, asynchronous):
  - last = 1, so port 0 wins the first contention; hold_cnt = 0; rd_pend = 0; rd_owner = 0.
  - gnt0/gnt1/rvalid0/rvalid1/mem_we are 0 while reset is asserted.
  - Reset during an outstanding read drops the response: no rvalid after release.
- Boundaries:
  - Address wrap is the requester's concern; addresses pass through unmodified.
  - MAX_HOLD = 1 gives strict alternation under contention.

Decomposition:
- Shared package (mem_pkg): WORD_W = 32; port-index type (1 bit); constants PORT_IF = 0 and PORT_LSU = 1.
- One sub-module is natural: rr_pick, the combinational 2-way pick from req, last and hold_cnt, producing the grant vector.
- Muxing, counters and the response path stay in ram_arbiter.

Test Plan:
- Reset, then req0 = 1, we0 = 0, a0 = 0x010 alone for 3 cycles: gnt0 is high each cycle, and rvalid0 rises 1 cycle after the first grant with rd0 = mem[0x010]. rvalid1 stays 0 throughout.
- Write then read: port 1 writes 0xDEADBEEF to 0x1FF, then reads 0x1FF on the next cycle. rvalid1 follows with rd1 = 0xDEADBEEF. mem_we is high only in the write cycle.
- Contention with MAX_HOLD = 4: req0 and req1 held high continuously (reads) from reset. The grant sequence is 0,0,0,0,1,1,1,1,0,…, and each rvalid matches its owner one cycle later.
- Single gap: port 1 requests once while port 0 streams. Port 1 is granted within MAX_HOLD cycles, and port 0 resumes the next cycle.
- Reset mid-read: port 0 read granted, then rst low before the next edge. No rvalid0 pulse occurs, and after release the next contention grants port 0 first.
- Idle: both req low for 5 cycles → mem_we = 0, no gnt, no rvalid, and hold_cnt returns to 0.
